conv2d_stream_engine: RTL and testbench

- Parametrised successor to the fixed 5x5/3x3 sliding-window convolver.
- Streams in a square image and, optionally, a runtime-loadable signed kernel over a valid/ready input port.
- Computes the strided 2-D valid convolution with one MAC per cycle and streams results out in row-major order on a valid/ready output port with back-pressure.
- Sits between the DMA input FIFO and the result FIFO of the accelerator datapath.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_mac.sv | 31 +++
 rtl/conv2d_stream_engine.sv | 202 ++++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming 2-D convolution engine.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KERNEL,
        LOAD_IMAGE,
        COMPUTE,
        OUTPUT
    } state_t;

    // Value held in the kernel centre tap after reset; all other taps are 0.
    localparam int KER_RESET_TAP = 1;

    function automatic int acc_width(input int data_w, input int k_size);
        return 2 * data_w + $clog2(k_size * k_size);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with clear priority over enable; result is visible one cycle after the update.
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = a * b;
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Strided valid 2-D convolution, one MAC per cycle; first result K*K+1 cycles after the last image beat,
// each result held until out_ready. Define CONV_RELU_EN to clamp negative results to zero.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int IN_SIZE  = 5,
    parameter  int K_SIZE   = 3,
    parameter  int STRIDE   = 1,
    localparam int OUT_SIZE = (IN_SIZE - K_SIZE) / STRIDE + 1,
    localparam int ACC_W    = acc_width(DATA_W, K_SIZE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_kernel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    busy,
    output logic                    done
);

    localparam int NPIX   = IN_SIZE * IN_SIZE;
    localparam int NTAP   = K_SIZE * K_SIZE;
    localparam int IMG_AW = $clog2(NPIX);
    localparam int KER_AW = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam int CNT_W  = $clog2(NPIX + 1);
    localparam int KW     = $clog2(K_SIZE + 1);
    localparam int OW     = $clog2(OUT_SIZE + 1);
    localparam int CENTRE = (K_SIZE / 2) * K_SIZE + K_SIZE / 2;

    localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] KER_LAST = CNT_W'(NTAP - 1);
    localparam logic [KW-1:0]    K_LAST   = KW'(K_SIZE - 1);
    localparam logic [OW-1:0]    O_LAST   = OW'(OUT_SIZE - 1);

    state_t                   state;
    logic [CNT_W-1:0]         load_cnt;
    logic [KW-1:0]            ki;
    logic [KW-1:0]            kj;
    logic [OW-1:0]            orow;
    logic [OW-1:0]            ocol;
    logic                     acc_done;
    logic signed [DATA_W-1:0] img [NPIX];
    logic signed [DATA_W-1:0] ker [NTAP];

    logic                     in_fire;
    logic                     out_fire;
    logic                     img_we;
    logic                     ker_we;
    logic                     mac_en;
    logic [CNT_W-1:0]         wr_idx;
    logic [IMG_AW-1:0]        img_addr;
    logic [KER_AW-1:0]        ker_addr;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  result;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // The first beat of any frame lands in element 0, whatever the counter holds.
    assign wr_idx   = (state == IDLE) ? '0 : load_cnt;
    assign img_we   = in_fire && ((state == IDLE && !in_kernel) || state == LOAD_IMAGE);
    assign ker_we   = in_fire && ((state == IDLE && in_kernel) || state == LOAD_KERNEL);
    assign mac_en   = (state == COMPUTE) && !acc_done;

    assign img_addr = IMG_AW'((int'(orow) * STRIDE + int'(ki)) * IN_SIZE + int'(ocol) * STRIDE + int'(kj));
    assign ker_addr = KER_AW'(int'(ki) * K_SIZE + int'(kj));

`ifdef CONV_RELU_EN
    assign result = acc[ACC_W-1] ? '0 : acc;
`else
    assign result = acc;
`endif

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clear (out_fire),
        .en    (mac_en),
        .a     (img[img_addr]),
        .b     (ker[ker_addr]),
        .acc   (acc)
    );

    // Image buffer contents are meaningless until a full frame has been loaded, so it carries no reset.
    always_ff @(posedge clk) begin
        if (img_we) begin
            img[IMG_AW'(wr_idx)] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            load_cnt  <= '0;
            ki        <= '0;
            kj        <= '0;
            orow      <= '0;
            ocol      <= '0;
            acc_done  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int t = 0; t < NTAP; t++) begin
                ker[KER_AW'(t)] <= (t == CENTRE) ? DATA_W'(KER_RESET_TAP) : '0;
            end
        end else begin
            done <= 1'b0;
            if (ker_we) begin
                ker[KER_AW'(wr_idx)] <= in_data;
            end
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        load_cnt <= CNT_W'(1);
                        if (!in_kernel) begin
                            state <= LOAD_IMAGE;
                            busy  <= 1'b1;
                        end else if (NTAP > 1) begin
                            state <= LOAD_KERNEL;
                            busy  <= 1'b1;
                        end
                    end
                end
                LOAD_KERNEL: begin
                    if (in_fire) begin
                        if (load_cnt == KER_LAST) begin
                            load_cnt <= '0;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                LOAD_IMAGE: begin
                    if (in_fire) begin
                        if (load_cnt == IMG_LAST) begin
                            load_cnt <= '0;
                            in_ready <= 1'b0;
                            state    <= COMPUTE;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    // After the final tap the accumulator needs one more cycle before it is registered out.
                    if (!acc_done) begin
                        if (kj == K_LAST) begin
                            kj <= '0;
                            if (ki == K_LAST) begin
                                ki       <= '0;
                                acc_done <= 1'b1;
                            end else begin
                                ki <= ki + 1'b1;
                            end
                        end else begin
                            kj <= kj + 1'b1;
                        end
                    end else begin
                        acc_done  <= 1'b0;
                        out_data  <= result;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (ocol == O_LAST) begin
                            ocol <= '0;
                            if (orow == O_LAST) begin
                                orow     <= '0;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                in_ready <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                orow  <= orow + 1'b1;
                                state <= COMPUTE;
                            end
                        end else begin
                            ocol  <= ocol + 1'b1;
                            state <= COMPUTE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench: a default 5x5/K3/S1 engine and a 7x7/K3/S2 engine share stimulus through a select mux.
module tb_conv2d_stream_engine;

    localparam int DW = 8;
    localparam int AW = 2 * DW + $clog2(9);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sel;
    logic                 in_valid;
    logic                 in_kernel;
    logic                 out_ready;
    logic [DW-1:0]        in_data;
    logic                 ir1, ir2, ov1, ov2, bz1, bz2, dn1, dn2;
    logic signed [AW-1:0] od1, od2;
    logic                 o_in_ready, o_valid, o_busy, o_done;
    logic signed [AW-1:0] o_data;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int beats[$];
    int exp_q[$];

    always #5 clk = ~clk;

    assign o_in_ready = sel ? ir2 : ir1;
    assign o_valid    = sel ? ov2 : ov1;
    assign o_busy     = sel ? bz2 : bz1;
    assign o_done     = sel ? dn2 : dn1;
    assign o_data     = sel ? od2 : od1;

    always @(negedge clk) if (o_done) done_cnt++;

    conv2d_stream_engine #(
        .DATA_W(DW), .IN_SIZE(5), .K_SIZE(3), .STRIDE(1)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(ir1),
        .in_data(in_data), .in_kernel(in_kernel), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .busy(bz1), .done(dn1)
    );

    conv2d_stream_engine #(
        .DATA_W(DW), .IN_SIZE(7), .K_SIZE(3), .STRIDE(2)
    ) dut_s2 (
        .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(ir2),
        .in_data(in_data), .in_kernel(in_kernel), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2), .busy(bz2), .done(dn2)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic send_beats(input logic kern);
        int cyc;
        foreach (beats[k]) begin
            in_valid  = 1'b1;
            in_data   = DW'(beats[k]);
            in_kernel = kern;
            cyc = 0;
            while (!o_in_ready && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc == 100) check("in_ready_timeout", o_in_ready, 1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_kernel = 1'b0;
    endtask

    // Loads the image in beats, then drains exp_q, optionally stalling one result for 20 cycles.
    task automatic run_frame(input string tag, input int stall_idx);
        int lat, idx, cyc, d0;
        logic signed [AW-1:0] held;
        d0 = done_cnt;
        send_beats(1'b0);
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 10);
        idx = 0;
        cyc = 0;
        while (idx < exp_q.size() && cyc < 2000) begin
            if (o_valid) begin
                if (idx == stall_idx) begin
                    out_ready = 1'b0;
                    held = o_data;
                    repeat (20) @(negedge clk);
                    check({tag, "_stall_data"}, o_data, held);
                    check({tag, "_stall_valid"}, o_valid, 1);
                    check({tag, "_stall_in_ready"}, o_in_ready, 0);
                    check({tag, "_stall_busy"}, o_busy, 1);
                    out_ready = 1'b1;
                end
                check($sformatf("%s_out%0d", tag, idx), o_data, exp_q[idx]);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_count"}, idx, exp_q.size());
        @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_idle_busy"}, o_busy, 0);
        check({tag, "_idle_ready"}, o_in_ready, 1);
    endtask

    initial begin
        reset     = 1'b1;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_kernel = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", o_in_ready, 1);
        check("rst_out_valid", o_valid, 0);
        check("rst_out_data", o_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset kernel passes the centre pixel of each window.
        beats = {};
        for (int v = 1; v <= 25; v++) beats.push_back(v);
        exp_q = {};
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) exp_q.push_back(5 * r + c + 7);
        run_frame("centre", -1);

        // Kernel rows [1 0 1].
        beats = {};
        for (int t = 0; t < 9; t++) beats.push_back((t % 3 == 1) ? 0 : 1);
        send_beats(1'b1);
        check("kload_busy", o_busy, 0);
        check("kload_ready", o_in_ready, 1);
        beats = {};
        for (int v = 1; v <= 25; v++) beats.push_back(v);
        exp_q = {};
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) exp_q.push_back(42 + 30 * r + 6 * c);
        run_frame("cols", -1);

        // All -1 kernel over an all-ones image, with the 4th result stalled.
        beats = {};
        for (int t = 0; t < 9; t++) beats.push_back(-1);
        send_beats(1'b1);
        beats = {};
        for (int v = 0; v < 25; v++) beats.push_back(1);
        exp_q = {};
`ifdef CONV_RELU_EN
        for (int t = 0; t < 9; t++) exp_q.push_back(0);
`else
        for (int t = 0; t < 9; t++) exp_q.push_back(-9);
`endif
        run_frame("neg", 3);

        // Reset asserted while beat 12 of an image is presented.
        beats = {};
        for (int v = 1; v <= 11; v++) beats.push_back(v);
        send_beats(1'b0);
        check("mid_busy", o_busy, 1);
        in_valid = 1'b1;
        in_data  = 8'd12;
        reset    = 1'b1;
        #1;
        check("midrst_in_ready", o_in_ready, 1);
        check("midrst_out_valid", o_valid, 0);
        check("midrst_out_data", o_data, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_done", o_done, 0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        beats = {};
        for (int v = 1; v <= 25; v++) beats.push_back(v);
        exp_q = {};
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) exp_q.push_back(5 * r + c + 7);
        run_frame("post_reset", -1);

        // 7x7 image, stride 2, all-ones kernel, image of 2s.
        sel = 1'b1;
        @(negedge clk);
        beats = {};
        for (int t = 0; t < 9; t++) beats.push_back(1);
        send_beats(1'b1);
        beats = {};
        for (int v = 0; v < 49; v++) beats.push_back(2);
        exp_q = {};
        for (int t = 0; t < 9; t++) exp_q.push_back(18);
        run_frame("stride2", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
